// File: rtl/axi_defs.sv
// Shared AXI read-channel constants and arbiter FSM encodings.
package axi_defs;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_INSTR = 3'b100;
    localparam logic [2:0] AXI_PROT_DATA  = 3'b000;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LOAD  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

endpackage

// File: rtl/axi_rd_arbiter_arb2.sv
// Two-way grant logic: req/gnt bit 0 = fetch, bit 1 = load.
// `ARB_RR_EN selects round-robin; otherwise load has fixed priority.
module arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef ARB_RR_EN
    logic last_q;  // 1 = load was granted last

    always_ff @(posedge clk) begin
        if (rst)
            last_q <= 1'b1;
        else if (|gnt)
            last_q <= gnt[1];
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (&req)
                gnt = last_q ? 2'b01 : 2'b10;
            else
                gnt = req;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[1])
                gnt = 2'b10;
            else if (req[0])
                gnt = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one single-beat AXI read port between instruction fetch and data load.
// Arbitration variant selected by `ARB_RR_EN (see arb2).
module axi_rd_arbiter
    import axi_defs::*;
#(
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned FETCH_ID = 0,
    parameter int unsigned LOAD_ID  = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req_valid,
    input  logic [ADDR_W-1:0] f_req_addr,
    output logic              f_req_ready,
    input  logic              f_flush,
    output logic              f_resp_valid,
    output logic [DATA_W-1:0] f_resp_data,
    output logic              f_resp_err,

    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [2:0]        d_req_size,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic              d_resp_err,

    output logic [ID_W-1:0]   ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic [2:0]        ARPORT,
    output logic              ARVALID,
    input  logic              ARREADY,

    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);

    state_t            state_q, state_d;
    logic [1:0]        req, gnt;
    logic              owner_q;
    logic              drop_q;
    logic              f_resp_q, d_resp_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic              r_beat;
    logic              unused_rresp;

    assign unused_rresp = RRESP[0];

    // A flush in IDLE withholds the fetch grant for that cycle.
    assign req = {d_req_valid, f_req_valid & ~f_flush};

    arb2 u_arb2 (
        .clk (clk),
        .rst (rst),
        .en  (state_q == S_IDLE),
        .req (req),
        .gnt (gnt)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|gnt)   state_d = S_AR;
            S_AR:    if (ARREADY) state_d = S_R;
            S_R:     if (RVALID)  state_d = S_IDLE;
            default:              state_d = S_IDLE;
        endcase
    end

    always_comb begin
        f_req_ready = gnt[0];
        d_req_ready = gnt[1];
        ARVALID     = (state_q == S_AR);
        RREADY      = (state_q == S_R);
    end

    assign r_beat = (state_q == S_R) && RVALID;
    assign ARLEN  = 8'd0;

    // NOTE: the response data register is reset too; it is small and keeps outputs at 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= PORT_FETCH;
            drop_q   <= 1'b0;
            f_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            ARID     <= '0;
            ARADDR   <= '0;
            ARSIZE   <= 3'd0;
            ARBURST  <= 2'b00;
            ARPORT   <= 3'b000;
        end else begin
            f_resp_q <= 1'b0;
            d_resp_q <= 1'b0;

            if (state_q == S_IDLE && (|gnt)) begin
                owner_q <= gnt[1];
                ARBURST <= AXI_BURST_INCR;
                if (gnt[1]) begin
                    ARID   <= ID_W'(LOAD_ID);
                    ARADDR <= d_req_addr;
                    ARSIZE <= d_req_size;
                    ARPORT <= AXI_PROT_DATA;
                end else begin
                    ARID   <= ID_W'(FETCH_ID);
                    ARADDR <= f_req_addr;
                    ARSIZE <= 3'd3;
                    ARPORT <= AXI_PROT_INSTR;
                end
            end

            if (r_beat)
                drop_q <= 1'b0;
            else if (state_q != S_IDLE && owner_q == PORT_FETCH && f_flush)
                drop_q <= 1'b1;

            if (r_beat) begin
                data_q   <= RDATA;
                err_q    <= RRESP[1];
                f_resp_q <= (owner_q == PORT_FETCH) && !drop_q && !f_flush;
                d_resp_q <= (owner_q == PORT_LOAD);
            end
        end
    end

    // A flush during the response cycle still suppresses the fetch pulse.
    assign f_resp_valid = f_resp_q & ~f_flush;
    assign f_resp_data  = data_q;
    assign f_resp_err   = err_q;
    assign d_resp_valid = d_resp_q;
    assign d_resp_data  = data_q;
    assign d_resp_err   = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter with a hand-driven AXI slave.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req_valid, f_flush, f_req_ready, f_resp_valid, f_resp_err;
    logic [63:0] f_req_addr, f_resp_data;
    logic        d_req_valid, d_req_ready, d_resp_valid, d_resp_err;
    logic [63:0] d_req_addr, d_resp_data;
    logic [2:0]  d_req_size;
    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE, ARPORT;
    logic [1:0]  ARBURST, RRESP;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [63:0] RDATA;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int hs0;
    logic exp_load_first;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
        .f_flush(f_flush), .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
        .f_resp_err(f_resp_err),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_size(d_req_size),
        .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .d_resp_err(d_resp_err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARPORT(ARPORT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ARVALID && ARREADY) hs_cnt <= hs_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        f_req_valid = 0; f_req_addr = '0; f_flush = 0;
        d_req_valid = 0; d_req_addr = '0; d_req_size = '0;
        ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0;
        tick(); tick();
        settle();
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_fresp", f_resp_valid, 0);
        chk("rst_dresp", d_resp_valid, 0);
        rst = 1'b0;

        // 1: fetch only, minimum latency
        f_req_valid = 1; f_req_addr = 64'h8000_0000; ARREADY = 1;
        settle();
        chk("t1_fready", f_req_ready, 1);
        chk("t1_dready", d_req_ready, 0);
        tick(); f_req_valid = 0; settle();
        chk("t1_arvalid", ARVALID, 1);
        chk("t1_arid", ARID, 0);
        chk("t1_arsize", ARSIZE, 3);
        chk("t1_arport", ARPORT, 3'b100);
        chk("t1_arlen", ARLEN, 0);
        chk("t1_arburst", ARBURST, 2'b01);
        chk("t1_araddr", ARADDR, 64'h8000_0000);
        tick(); RVALID = 1; RDATA = 64'h1122_3344_5566_7788; RRESP = 0; settle();
        chk("t1_rready", RREADY, 1);
        chk("t1_arvalid_lo", ARVALID, 0);
        tick(); RVALID = 0; settle();
        chk("t1_fresp", f_resp_valid, 1);
        chk("t1_fdata", f_resp_data, 64'h1122_3344_5566_7788);
        chk("t1_ferr", f_resp_err, 0);
        chk("t1_dresp", d_resp_valid, 0);
        tick(); settle();
        chk("t1_fresp_pulse", f_resp_valid, 0);

        // 2: contention; last grant was fetch so both variants pick load
        f_req_valid = 1; f_req_addr = 64'h8000_0020;
        d_req_valid = 1; d_req_addr = 64'h8000_1000; d_req_size = 3'd2;
        settle();
        chk("t2_dready", d_req_ready, 1);
        chk("t2_fready", f_req_ready, 0);
        tick(); d_req_valid = 0; settle();
        chk("t2_arid", ARID, 1);
        chk("t2_arsize", ARSIZE, 2);
        chk("t2_arport", ARPORT, 3'b000);
        chk("t2_araddr", ARADDR, 64'h8000_1000);
        tick(); RVALID = 1; RDATA = 64'hAAAA_0000_BBBB_1111; settle();
        tick(); RVALID = 0; settle();
        chk("t2_dresp", d_resp_valid, 1);
        chk("t2_ddata", d_resp_data, 64'hAAAA_0000_BBBB_1111);
        chk("t2_fresp", f_resp_valid, 0);
        chk("t2_b2b_fready", f_req_ready, 1);
        tick(); f_req_valid = 0; settle();
        chk("t2_arid_f", ARID, 0);
        chk("t2_araddr_f", ARADDR, 64'h8000_0020);
        tick(); RVALID = 1; RDATA = 64'h0F0F_0F0F_1234_5678; settle();
        tick(); RVALID = 0; settle();
        chk("t2_fresp2", f_resp_valid, 1);
        chk("t2_fdata2", f_resp_data, 64'h0F0F_0F0F_1234_5678);

        // 3: ARREADY stalled 5 cycles
        ARREADY = 0;
        f_req_valid = 1; f_req_addr = 64'h8000_0040;
        settle();
        chk("t3_fready", f_req_ready, 1);
        tick(); f_req_valid = 0;
        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t3_arvalid_hold", ARVALID, 1);
            chk("t3_araddr_hold", ARADDR, 64'h8000_0040);
            chk("t3_arid_hold", ARID, 0);
            tick();
        end
        ARREADY = 1; settle();
        chk("t3_arvalid_last", ARVALID, 1);
        tick(); RVALID = 1; RDATA = 64'h3333_4444_5555_6666; settle();
        chk("t3_arvalid_lo", ARVALID, 0);
        chk("t3_rready", RREADY, 1);
        tick(); RVALID = 0; settle();
        chk("t3_fresp", f_resp_valid, 1);
        chk("t3_fdata", f_resp_data, 64'h3333_4444_5555_6666);
        chk("t3_handshakes", hs_cnt - hs0, 1);

        // 4: flush in R drops the fetch response
        f_req_valid = 1; f_req_addr = 64'h8000_0050; settle();
        chk("t4_fready", f_req_ready, 1);
        tick(); f_req_valid = 0; settle();
        tick(); f_flush = 1; RVALID = 1; RDATA = 64'hDEAD_BEEF_DEAD_BEEF; settle();
        chk("t4_rready", RREADY, 1);
        tick(); f_flush = 0; RVALID = 0; settle();
        chk("t4_fresp_dropped", f_resp_valid, 0);
        chk("t4_rready_lo", RREADY, 0);
        chk("t4_arvalid_lo", ARVALID, 0);
        f_req_valid = 1; f_req_addr = 64'h8000_0010; settle();
        chk("t4_fready2", f_req_ready, 1);
        tick(); f_req_valid = 0; settle();
        chk("t4_araddr2", ARADDR, 64'h8000_0010);
        tick(); RVALID = 1; RDATA = 64'h0102_0304_0506_0708; settle();
        tick(); RVALID = 0; settle();
        chk("t4_fresp2", f_resp_valid, 1);
        chk("t4_fdata2", f_resp_data, 64'h0102_0304_0506_0708);

        // 5: load error response, then clean load
        d_req_valid = 1; d_req_addr = 64'h8000_2000; d_req_size = 3'd3; settle();
        chk("t5_dready", d_req_ready, 1);
        tick(); d_req_valid = 0; settle();
        tick(); RVALID = 1; RRESP = 2'b11; RDATA = 64'h5; settle();
        tick(); RVALID = 0; RRESP = 0; settle();
        chk("t5_dresp", d_resp_valid, 1);
        chk("t5_derr", d_resp_err, 1);
        d_req_valid = 1; d_req_addr = 64'h8000_2008; settle();
        chk("t5_dready2", d_req_ready, 1);
        tick(); d_req_valid = 0; settle();
        tick(); RVALID = 1; RDATA = 64'h6; settle();
        tick(); RVALID = 0; settle();
        chk("t5_dresp2", d_resp_valid, 1);
        chk("t5_derr2", d_resp_err, 0);

        // flush in IDLE blocks the fetch grant; no transaction follows
        f_req_valid = 1; f_flush = 1; settle();
        chk("fl_idle_fready", f_req_ready, 0);
        tick(); f_req_valid = 0; f_flush = 0; settle();
        chk("fl_idle_noar", ARVALID, 0);

        // 2b: contention with last grant = load
        exp_load_first = 1'b1;
`ifdef ARB_RR_EN
        exp_load_first = 1'b0;
`endif
        f_req_valid = 1; f_req_addr = 64'h8000_0060;
        d_req_valid = 1; d_req_addr = 64'h8000_3000; d_req_size = 3'd1;
        settle();
        chk("t2b_dready", d_req_ready, exp_load_first);
        chk("t2b_fready", f_req_ready, !exp_load_first);
        tick(); f_req_valid = 0; d_req_valid = 0; settle();
        chk("t2b_arid", ARID, exp_load_first ? 64'd1 : 64'd0);
        tick(); RVALID = 1; RDATA = 64'h7; settle();
        tick(); RVALID = 0; settle();
        chk("t2b_dresp", d_resp_valid, exp_load_first);
        chk("t2b_fresp", f_resp_valid, !exp_load_first);

        // 6: reset while in AR
        ARREADY = 0;
        f_req_valid = 1; f_req_addr = 64'h8000_0080; settle();
        tick(); f_req_valid = 0; settle();
        chk("t6_arvalid", ARVALID, 1);
        rst = 1;
        tick(); settle();
        chk("t6_arvalid_rst", ARVALID, 0);
        chk("t6_rready_rst", RREADY, 0);
        chk("t6_fresp_rst", f_resp_valid, 0);
        chk("t6_dresp_rst", d_resp_valid, 0);
        rst = 0;
        f_req_valid = 1; f_req_addr = 64'h8000_0090; settle();
        chk("t6_fready", f_req_ready, 1);
        tick(); f_req_valid = 0; ARREADY = 1; settle();
        chk("t6_arvalid2", ARVALID, 1);
        chk("t6_araddr2", ARADDR, 64'h8000_0090);
        tick(); RVALID = 1; RDATA = 64'h9999_8888_7777_6666; settle();
        tick(); RVALID = 0; settle();
        chk("t6_fresp", f_resp_valid, 1);
        chk("t6_fdata", f_resp_data, 64'h9999_8888_7777_6666);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
